// File: rtl/mem_wb_unit.sv
// MEM/WB stage: issues data-memory loads/stores through a req/ack handshake and
// produces the register-file write-back, branch redirect and a sticky fault flag.
module mem_wb_unit #(
  parameter int unsigned DM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_em,
  input  logic        Zero_em,
  input  logic        Overflow_em,
  input  logic [31:0] ALUout_em,
  input  logic [4:0]  Rw_em,
  input  logic        MemWr_em,
  input  logic        Branch_em,
  input  logic        MemtoReg_em,
  input  logic        RegWr_em,
  input  logic [31:0] busB_em,
  input  logic        valid_em,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [4:0]  Rw,
  output logic [31:0] Di,
  output logic        WE,
  output logic        stall,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        mem_err
);

  localparam int unsigned CNT_W = (DM_TIMEOUT < 2) ? 1 : $clog2(DM_TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dm_req_d, dm_we_d, we_d, br_taken_d, mem_err_d;
  logic [31:0]        dm_addr_d, dm_wdata_d, di_d, br_target_d;
  logic [4:0]         rw_d;
  logic [4:0]         op_rw_q, op_rw_d;
  logic               op_regwr_q, op_regwr_d;
  logic               op_load_q, op_load_d;
  logic               is_mem;
  logic               bad_access;

  assign is_mem     = MemWr_em | MemtoReg_em;
  assign bad_access = (ALUout_em[1:0] != 2'b00) | Overflow_em;

  // Upstream hold request: memory op waiting to start, or access still outstanding.
  assign stall = ((state_q == ACCESS) & ~dm_ack) |
                 ((state_q == IDLE) & valid_em & is_mem);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm_req_d    = dm_req;
    dm_we_d     = dm_we;
    dm_addr_d   = dm_addr;
    dm_wdata_d  = dm_wdata;
    rw_d        = Rw;
    di_d        = Di;
    we_d        = 1'b0;
    br_taken_d  = 1'b0;
    br_target_d = br_target;
    mem_err_d   = mem_err;
    op_rw_d     = op_rw_q;
    op_regwr_d  = op_regwr_q;
    op_load_d   = op_load_q;

    case (state_q)
      IDLE: begin
        if (valid_em) begin
          br_taken_d  = Branch_em & Zero_em;
          br_target_d = PC_em;
          if (is_mem) begin
            if (bad_access) begin
              mem_err_d = 1'b1;
            end else begin
              state_d    = ACCESS;
              cnt_d      = '0;
              dm_req_d   = 1'b1;
              dm_we_d    = MemWr_em;
              dm_addr_d  = {ALUout_em[31:2], 2'b00};
              dm_wdata_d = busB_em;
              op_rw_d    = Rw_em;
              op_regwr_d = RegWr_em;
              op_load_d  = ~MemWr_em;
            end
          end else begin
            rw_d = Rw_em;
            di_d = ALUout_em;
            we_d = RegWr_em & ~Overflow_em & (Rw_em != 5'd0);
          end
        end
      end
      ACCESS: begin
        // An ack on the timeout edge still completes the access.
        if (dm_ack) begin
          state_d  = IDLE;
          cnt_d    = '0;
          dm_req_d = 1'b0;
          if (op_load_q) begin
            rw_d = op_rw_q;
            di_d = dm_rdata;
            we_d = op_regwr_q & (op_rw_q != 5'd0);
          end
        end else if (cnt_q + CNT_W'(1) == CNT_W'(DM_TIMEOUT)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          dm_req_d  = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      Rw         <= '0;
      Di         <= '0;
      WE         <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= '0;
      mem_err    <= 1'b0;
      op_rw_q    <= '0;
      op_regwr_q <= 1'b0;
      op_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req     <= dm_req_d;
      dm_we      <= dm_we_d;
      dm_addr    <= dm_addr_d;
      dm_wdata   <= dm_wdata_d;
      Rw         <= rw_d;
      Di         <= di_d;
      WE         <= we_d;
      br_taken   <= br_taken_d;
      br_target  <= br_target_d;
      mem_err    <= mem_err_d;
      op_rw_q    <= op_rw_d;
      op_regwr_q <= op_regwr_d;
      op_load_q  <= op_load_d;
    end
  end

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL have parameter DM_TIMEOUT, default 15, the maximum number of cycles dm_req is held waiting for dm_ack.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have ports PC_em[31:0], Zero_em, Overflow_em, ALUout_em[31:0], Rw_em[4:0], MemWr_em, Branch_em, MemtoReg_em, RegWr_em and busB_em[31:0], all inputs, which carry the EX/MEM pipeline-register contents.
REQ-005 SHALL have port valid_em, input, 1, which qualifies the EX/MEM contents for the current cycle.
REQ-006 SHALL have outputs dm_req, dm_we, dm_addr[31:0] and dm_wdata[31:0], which form the data-memory request.
REQ-007 SHALL have inputs dm_ack and dm_rdata[31:0], which form the data-memory response.
REQ-008 SHALL have outputs Rw[4:0], Di[31:0] and WE, which form the register-file write-back port.
REQ-009 SHALL have output stall, 1, which requests the upstream stage to hold its EX/MEM contents.
REQ-010 SHALL have outputs br_taken, 1, and br_target[31:0], which carry the branch redirect.
REQ-011 SHALL have output mem_err, 1, a sticky memory-fault flag.

Function
REQ-012 SHALL implement the FSM states IDLE and ACCESS.
REQ-013 SHALL accept an operation in IDLE at a rising edge when valid_em=1.
REQ-014 SHALL treat an accepted operation with MemWr_em=1 as a store; MemWr_em SHALL take priority over MemtoReg_em.
REQ-015 SHALL treat an accepted operation with MemWr_em=0 and MemtoReg_em=1 as a load.
REQ-016 SHALL treat any other accepted operation as ALU-only.
REQ-017 SHALL register an ALU-only operation to the write-back port with 1-cycle latency: Rw=Rw_em, Di=ALUout_em, and a one-cycle WE pulse equal to RegWr_em & ~Overflow_em & (Rw_em!=0).
REQ-018 SHALL, on acceptance of a load or store, go to ACCESS and drive, from the next cycle: dm_req=1, dm_addr={ALUout_em[31:2],2'b00}, dm_we=MemWr_em, dm_wdata=busB_em.
REQ-019 SHALL hold dm_req, dm_we, dm_addr and dm_wdata stable in ACCESS until dm_ack is sampled high.
REQ-020 SHALL, on dm_ack sampled high in ACCESS, deassert dm_req at that same edge and return to IDLE.
REQ-021 SHALL, when a load completes, latch dm_rdata at the ack edge into Di, set Rw=Rw_em and pulse WE=RegWr_em & (Rw_em!=0) for one cycle.
REQ-022 SHALL NOT pulse WE when a store completes.
REQ-023 SHALL drive stall combinationally as: (state==ACCESS & ~(dm_ack)) | (state==IDLE & valid_em & (MemWr_em | MemtoReg_em)).
REQ-024 SHALL rely on upstream holding the EX/MEM inputs constant while stall=1; Rw_em and RegWr_em SHALL be captured at acceptance.
REQ-025 SHALL skip the access when a load or store is accepted with ALUout_em[1:0]!=0 or Overflow_em=1: no dm_req, mem_err set to 1, no WE, state stays IDLE.
REQ-026 SHALL count cycles with dm_req=1 in ACCESS; when the count reaches DM_TIMEOUT without ack, it SHALL drop dm_req, set mem_err, suppress WE and return to IDLE.
REQ-027 SHALL treat an ack arriving on the same edge the count reaches DM_TIMEOUT as a success.
REQ-028 SHALL ignore dm_ack while in IDLE.
REQ-029 SHALL register br_taken as a one-cycle pulse equal to valid_em & Branch_em & Zero_em at acceptance, with br_target=PC_em; branch evaluation SHALL be independent of memory stalls.
REQ-030 SHALL clear mem_err only by reset.

Reset
REQ-031 SHALL, while reset=0, force state=IDLE, the timeout counter to 0, and dm_req, dm_we, dm_addr, dm_wdata, Rw, Di, WE, br_taken, br_target and mem_err to 0, asynchronously.
REQ-032 SHALL, when reset asserts mid-ACCESS, drop dm_req immediately, produce no write-back for the aborted operation, and accept nothing on the first edge after release unless valid_em=1.

Verification
REQ-033 SHALL be verified with this ALU op: valid_em=1, RegWr_em=1, Rw_em=5, ALUout_em=0x0000002A, others 0 -> next cycle WE=1, Rw=5, Di=0x2A for exactly one cycle, and stall=0 throughout.
REQ-034 SHALL be verified with this load: MemtoReg_em=1, RegWr_em=1, Rw_em=8, ALUout_em=0x100, dm_ack delayed 3 cycles with dm_rdata=0xDEADBEEF -> dm_addr=0x100 and dm_we=0 held 3 cycles, stall high 4 cycles, then WE=1, Rw=8, Di=0xDEADBEEF for one cycle.
REQ-035 SHALL be verified with this store: MemWr_em=1, ALUout_em=0x204, busB_em=0x12345678, dm_ack after 1 cycle -> dm_we=1, dm_wdata=0x12345678 and WE never asserted.
REQ-036 SHALL be verified with this fault: load with ALUout_em=0x102, then a load to 0x100 with no ack for 15 cycles -> first: no dm_req and mem_err=1; second: dm_req high 15 cycles then low, WE never asserted, and the FSM back in IDLE.
REQ-037 SHALL be verified with these branch and overflow cases: Branch_em=1, Zero_em=1, PC_em=0x40 -> br_taken pulse with br_target=0x40; ALU op with Overflow_em=1 and RegWr_em=1 -> WE stays 0.
REQ-038 SHALL be verified with reset=0 asserted 2 cycles into ACCESS -> dm_req=0 within the same cycle, all outputs 0, and no WE after release.
